sram_port_arbiter: RTL and testbench
====================================

# sram_port_arbiter

Two-requester arbiter sharing the single-ported 1024x32 program/data SRAM of the SAP-3 core. Port 0 is the CPU memory interface; port 1 is the program loader/debug path. Each cycle the block grants at most one requester, drives the SRAM control, address and data lines from that requester, and routes the read data returned one cycle later back to it with a valid strobe. A per-port lock lets one requester hold the SRAM for back-to-back bursts.

## Interface
- AW, 10: SRAM word-address width.
- DW, 32: data width.
- clk  in  1  clock; every register updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_i  in  2  per-port access request; bit k belongs to port k.
- we_i  in  2  per-port write select: 1 = write, 0 = read.
- lock_i  in  2  per-port burst lock, sampled with req_i.
- addr0_i, addr1_i  in  AW  per-port word address.
- wdata0_i, wdata1_i  in  DW  per-port write data.
- gnt_o  out  2  one-hot or zero grant, combinational in the request cycle.
- rvalid_o  out  2  read data valid, asserted the cycle after a granted read.
- rdata_o  out  DW  read data, shared by both ports and qualified by rvalid_o.
- sram_addr_o  out  AW  to the SRAM ADDR input.
- sram_din_o  out  DW  to the SRAM DIN input.
- sram_bm_o  out  DW  byte mask, tied to all ones.
- sram_wen_o  out  1  SRAM write enable, active high.
- sram_ren_o  out  1  SRAM read enable, active high.
- sram_men_o  out  1  SRAM memory enable; equals the OR of gnt_o.
- sram_dout_i  in  DW  SRAM DOUT, registered by the SRAM.

## Operation
- Owner FSM has three states: FREE, OWN0, OWN1. Reset state is FREE.
- FREE:
  - A single requesting port is granted.
  - If both ports request, the port selected by the priority rule (see Configuration) is granted.
  - A granted port with lock_i set moves the FSM to OWNk.
- OWNk:
  - Only port k can be granted. The other port's req_i is ignored and its gnt_o stays 0.
  - The FSM returns to FREE on the first cycle in which port k has req_i=1 with lock_i=0 (that access is still granted), or in which req_i[k]=0.
- When a port is granted, the SRAM is driven from that port's signals:
  - sram_addr_o = addrk_i; sram_din_o = wdatak_i.
  - sram_wen_o = we_i[k]; sram_ren_o = !we_i[k]; sram_men_o = 1.
- With no grant: sram_wen_o, sram_ren_o and sram_men_o are 0; sram_addr_o and sram_din_o are 0.
- Read return path:
  - A registered tag (valid bit plus port index) records each granted read.
  - In the next cycle, rvalid_o[tag] = 1 and rdata_o = sram_dout_i.
  - When the tag is invalid, rdata_o = 0.
- Writes produce no response. A write is complete at the edge that ends its grant cycle.
- Requesters hold req_i and their address, data, we and lock inputs stable until they see gnt_o. Dropping req_i before a grant withdraws the request and is legal.

## Timing
- Grant latency is 0 cycles: gnt_o is a combinational function of req_i and the FSM/priority state.
- Read latency: granted in cycle T, rvalid_o and rdata_o in cycle T+1.
- Throughput is one access per cycle. Back-to-back reads from different ports return in grant order, one per cycle.
- Read-after-write to the same address on consecutive cycles returns the new data, because the SRAM write completes at the end of cycle T.
- While rst=1: gnt_o=0, all sram_*_o enables=0, rvalid_o=0, rdata_o=0.
- Reset behaviour (applied at the edge where rst=1):
  - FSM goes to FREE and the round-robin pointer goes to port 0.
  - A pending read tag is cleared, so no rvalid_o is produced for it.
- Simultaneous release and new request: if port k releases its lock while the other port is requesting, the other port is granted in the following cycle. There are no bubble cycles beyond that one.

## Configuration
- SRAM_ARB_RR_EN defined: round-robin priority in FREE.
  - A 1-bit pointer names the favoured port.
  - After any grant in FREE, the pointer moves to the other port.
- SRAM_ARB_RR_EN undefined: fixed priority in FREE; port 0 always wins a tie.
- Lock semantics are identical in both builds.

## Structure
- Shared package sram_arb_pkg holds:
  - the owner-state enum (FREE, OWN0, OWN1);
  - SRAM_AW = 10 and SRAM_DW = 32;
  - the read-tag struct (valid, port).
- Sub-module sram_arb_pick: combinational two-way priority picker. Inputs are the request vector and the favoured port; output is the one-hot grant. It is instantiated once.
- Top level contains the FSM, the round-robin pointer, the read tag and the SRAM output muxing.

## Test plan
- Reset: hold rst for 3 cycles with req_i=2'b11 -> gnt_o=0, all enables 0, rvalid_o=0 throughout.
- Single read: SRAM preloaded with mem[0x005]=0xDEADBEEF; port 0 reads 0x005 -> gnt_o=01 in cycle T; rvalid_o=01 and rdata_o=0xDEADBEEF in T+1.
- Contention: req_i=11, both ports reading, for 4 cycles.
  - With SRAM_ARB_RR_EN: grants 01, 10, 01, 10.
  - Without it: grants 01, 01, 01, 01.
- Lock burst: port 1 writes 0x100..0x103 with lock_i[1]=1 on the first three words while port 0 requests continuously.
  - Port 0 is not granted for those 4 cycles and is granted in the 5th cycle.
  - Port 0 then reads 0x102 and gets the value written there.
- Write then read: port 0 writes 0x3FF=0x12345678, and in the next cycle port 1 reads 0x3FF -> rvalid_o=10 with rdata_o=0x12345678.
- Reset mid-read: grant a read in cycle T and assert rst in T+1 -> rvalid_o=0 in T+1 and T+2, and the FSM is in FREE.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types and sizes for the SAP-3 SRAM port arbiter
package sram_arb_pkg;

    localparam int SRAM_AW = 10;
    localparam int SRAM_DW = 32;

    typedef enum logic [1:0] {
        FREE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } own_state_t;

    // Pending read response: launched in the grant cycle, consumed the next
    typedef struct packed {
        logic valid;
        logic port;
    } rd_tag_t;

endpackage

// File: rtl/sram_arb_pick.sv
// rtl/sram_arb_pick.sv - two-way priority picker; fav names the port that wins a tie
module sram_arb_pick (
    input  logic [1:0] req,
    input  logic       fav,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = fav ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - CPU/loader arbiter for the shared 1024x32 SRAM with burst lock
// Optional build macro SRAM_ARB_RR_EN selects round-robin tie-break; default is port 0 priority.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int AW = SRAM_AW,
    parameter int DW = SRAM_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    req_i,
    input  logic [1:0]    we_i,
    input  logic [1:0]    lock_i,
    input  logic [AW-1:0] addr0_i,
    input  logic [AW-1:0] addr1_i,
    input  logic [DW-1:0] wdata0_i,
    input  logic [DW-1:0] wdata1_i,
    output logic [1:0]    gnt_o,
    output logic [1:0]    rvalid_o,
    output logic [DW-1:0] rdata_o,
    output logic [AW-1:0] sram_addr_o,
    output logic [DW-1:0] sram_din_o,
    output logic [DW-1:0] sram_bm_o,
    output logic          sram_wen_o,
    output logic          sram_ren_o,
    output logic          sram_men_o,
    input  logic [DW-1:0] sram_dout_i
);

    own_state_t state, state_nxt;
    rd_tag_t    tag;
    logic [1:0] pick_gnt;
    logic [1:0] gnt;
    logic       fav;
    logic       any_gnt;
    logic       sel;
    logic       sel_we;

`ifdef SRAM_ARB_RR_EN
    logic rr_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= 1'b0;
        end else if (state == FREE && any_gnt) begin
            // favour whichever port did not just win
            rr_ptr <= gnt[0];
        end
    end

    assign fav = rr_ptr;
`else
    assign fav = 1'b0;
`endif

    sram_arb_pick u_pick (
        .req (req_i),
        .fav (fav),
        .gnt (pick_gnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FREE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        gnt       = 2'b00;
        state_nxt = state;
        if (!rst) begin
            case (state)
                FREE: begin
                    gnt = pick_gnt;
                    if (pick_gnt[0] && lock_i[0]) begin
                        state_nxt = OWN0;
                    end else if (pick_gnt[1] && lock_i[1]) begin
                        state_nxt = OWN1;
                    end
                end
                OWN0: begin
                    gnt = {1'b0, req_i[0]};
                    if (!(req_i[0] && lock_i[0])) begin
                        state_nxt = FREE;
                    end
                end
                OWN1: begin
                    gnt = {req_i[1], 1'b0};
                    if (!(req_i[1] && lock_i[1])) begin
                        state_nxt = FREE;
                    end
                end
                default: state_nxt = FREE;
            endcase
        end
    end

    assign any_gnt = |gnt;
    assign sel     = gnt[1];
    assign sel_we  = sel ? we_i[1] : we_i[0];

    assign gnt_o       = gnt;
    assign sram_men_o  = any_gnt;
    assign sram_wen_o  = any_gnt & sel_we;
    assign sram_ren_o  = any_gnt & ~sel_we;
    assign sram_addr_o = !any_gnt ? '0 : (sel ? addr1_i : addr0_i);
    assign sram_din_o  = !any_gnt ? '0 : (sel ? wdata1_i : wdata0_i);
    assign sram_bm_o   = '1;

    always_ff @(posedge clk) begin
        if (rst) begin
            tag <= '0;
        end else begin
            tag.valid <= any_gnt & ~sel_we;
            tag.port  <= sel;
        end
    end

    // rst also masks the response combinationally so nothing leaks out during reset
    assign rvalid_o = (tag.valid && !rst) ? (tag.port ? 2'b10 : 2'b01) : 2'b00;
    assign rdata_o  = (tag.valid && !rst) ? sram_dout_i : '0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - randomized and directed checks of sram_port_arbiter against a reference model
module tb_sram_port_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req_i, we_i, lock_i;
    logic [9:0]  addr0_i, addr1_i;
    logic [31:0] wdata0_i, wdata1_i;
    logic [1:0]  gnt_o, rvalid_o;
    logic [31:0] rdata_o;
    logic [9:0]  sram_addr_o;
    logic [31:0] sram_din_o, sram_bm_o;
    logic        sram_wen_o, sram_ren_o, sram_men_o;
    logic [31:0] sram_dout_i;

    sram_port_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_i),
        .we_i        (we_i),
        .lock_i      (lock_i),
        .addr0_i     (addr0_i),
        .addr1_i     (addr1_i),
        .wdata0_i    (wdata0_i),
        .wdata1_i    (wdata1_i),
        .gnt_o       (gnt_o),
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .sram_addr_o (sram_addr_o),
        .sram_din_o  (sram_din_o),
        .sram_bm_o   (sram_bm_o),
        .sram_wen_o  (sram_wen_o),
        .sram_ren_o  (sram_ren_o),
        .sram_men_o  (sram_men_o),
        .sram_dout_i (sram_dout_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_pat(input int i);
        return (i == 5) ? 32'hDEADBEEF : (i * 32'h9E3779B1) ^ 32'hA5A50000;
    endfunction

    // Behavioural SRAM with registered DOUT, driven only by the DUT's SRAM pins
    logic        mem_init;
    logic [31:0] sram_mem [0:1023];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) sram_mem[i] <= init_pat(i);
        end else if (sram_men_o) begin
            if (sram_wen_o) sram_mem[sram_addr_o] <= sram_din_o;
            if (sram_ren_o) sram_dout_i <= sram_mem[sram_addr_o];
        end
    end

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: owner is -1 when nobody holds the SRAM
    logic [31:0] ref_mem [0:1023];
    int          owner;
    int          fav;
    int          exp_rv;
    logic [31:0] exp_rd;
    int          last_g;
    logic [1:0]  obs_gnt, obs_rv;
    logic [31:0] obs_rd;
    logic        obs_men;

    function automatic int model_grant();
        if (rst) return -1;
        if (owner >= 0) return req_i[owner] ? owner : -1;
        if (req_i == 2'b00) return -1;
        if (req_i == 2'b01) return 0;
        if (req_i == 2'b10) return 1;
`ifdef SRAM_ARB_RR_EN
        return fav;
`else
        return 0;
`endif
    endfunction

    task automatic cycle();
        int g;
        logic [1:0] eg;
        #4;
        g  = model_grant();
        eg = (g < 0) ? 2'b00 : (g == 0 ? 2'b01 : 2'b10);
        check_eq("gnt", gnt_o, eg);
        check_eq("men", sram_men_o, g >= 0);
        check_eq("wen", sram_wen_o, g >= 0 && we_i[g]);
        check_eq("ren", sram_ren_o, g >= 0 && !we_i[g]);
        check_eq("addr", sram_addr_o, g < 0 ? 10'd0 : (g == 0 ? addr0_i : addr1_i));
        check_eq("din", sram_din_o, g < 0 ? 32'd0 : (g == 0 ? wdata0_i : wdata1_i));
        check_eq("bm", sram_bm_o, 32'hFFFFFFFF);
        check_eq("rvalid", rvalid_o, (rst || exp_rv < 0) ? 2'b00 : (exp_rv == 0 ? 2'b01 : 2'b10));
        check_eq("rdata", rdata_o, (rst || exp_rv < 0) ? 32'd0 : exp_rd);
        obs_gnt = gnt_o;
        obs_rv  = rvalid_o;
        obs_rd  = rdata_o;
        obs_men = sram_men_o;
        last_g  = g;
        @(posedge clk);
        if (rst) begin
            owner  = -1;
            fav    = 0;
            exp_rv = -1;
        end else begin
            exp_rv = -1;
            if (g >= 0) begin
                if (we_i[g]) ref_mem[g == 0 ? addr0_i : addr1_i] = g == 0 ? wdata0_i : wdata1_i;
                else begin
                    exp_rv = g;
                    exp_rd = ref_mem[g == 0 ? addr0_i : addr1_i];
                end
            end
            if (owner >= 0) begin
                if (!(req_i[owner] && lock_i[owner])) owner = -1;
            end else if (g >= 0) begin
                owner = lock_i[g] ? g : -1;
                fav   = 1 - g;
            end
        end
        #1;
    endtask

    task automatic drive(input logic [1:0] rq, input logic [1:0] we, input logic [1:0] lk,
                         input logic [9:0] a0, input logic [9:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1);
        req_i = rq; we_i = we; lock_i = lk;
        addr0_i = a0; addr1_i = a1; wdata0_i = d0; wdata1_i = d1;
    endtask

    logic [1:0]  cont_exp [4];
    logic        pend [2];
    logic        p_we [2];
    logic        p_lk [2];
    logic [9:0]  p_ad [2];
    logic [31:0] p_dt [2];

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_pat(i);
        owner = -1; fav = 0; exp_rv = -1; exp_rd = '0; last_g = -1;
        mem_init = 1'b1;
        rst = 1'b1;
        drive(2'b11, 2'b00, 2'b00, 10'd1, 10'd2, 32'd0, 32'd0);

        // reset held with both ports requesting
        for (int i = 0; i < 3; i++) begin
            cycle();
            mem_init = 1'b0;
            check_eq("rst_gnt", obs_gnt, 2'b00);
            check_eq("rst_men", obs_men, 1'b0);
            check_eq("rst_rvalid", obs_rv, 2'b00);
        end
        rst = 1'b0;

        // single read of preloaded word
        drive(2'b01, 2'b00, 2'b00, 10'h005, 10'd0, 32'd0, 32'd0);
        cycle();
        check_eq("single_gnt", obs_gnt, 2'b01);
        drive(2'b00, 2'b00, 2'b00, 10'd0, 10'd0, 32'd0, 32'd0);
        cycle();
        check_eq("single_rvalid", obs_rv, 2'b01);
        check_eq("single_rdata", obs_rd, 32'hDEADBEEF);

        // contention from a freshly reset pointer
        rst = 1'b1;
        cycle();
        rst = 1'b0;
`ifdef SRAM_ARB_RR_EN
        cont_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
        cont_exp = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
        drive(2'b11, 2'b00, 2'b00, 10'h010, 10'h020, 32'd0, 32'd0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            check_eq("contend_gnt", obs_gnt, cont_exp[i]);
        end

        // port 1 locked write burst while port 0 waits to read 0x102
        drive(2'b10, 2'b10, 2'b10, 10'h102, 10'h100, 32'd0, 32'hB0B00100);
        cycle();
        check_eq("burst_gnt0", obs_gnt, 2'b10);
        for (int i = 1; i < 4; i++) begin
            drive(2'b11, 2'b10, (i == 3) ? 2'b00 : 2'b10, 10'h102, 10'h100 + 10'(i),
                  32'd0, 32'hB0B00100 + 32'(i));
            cycle();
            check_eq("burst_gnt", obs_gnt, 2'b10);
        end
        drive(2'b01, 2'b00, 2'b00, 10'h102, 10'd0, 32'd0, 32'd0);
        cycle();
        check_eq("burst_p0_gnt", obs_gnt, 2'b01);
        drive(2'b00, 2'b00, 2'b00, 10'd0, 10'd0, 32'd0, 32'd0);
        cycle();
        check_eq("burst_rd_valid", obs_rv, 2'b01);
        check_eq("burst_rd_data", obs_rd, 32'hB0B00102);

        // write by port 0 then immediate read by port 1 of the top word
        drive(2'b01, 2'b01, 2'b00, 10'h3FF, 10'd0, 32'h12345678, 32'd0);
        cycle();
        drive(2'b10, 2'b00, 2'b00, 10'd0, 10'h3FF, 32'd0, 32'd0);
        cycle();
        check_eq("raw_gnt", obs_gnt, 2'b10);
        drive(2'b00, 2'b00, 2'b00, 10'd0, 10'd0, 32'd0, 32'd0);
        cycle();
        check_eq("raw_rvalid", obs_rv, 2'b10);
        check_eq("raw_rdata", obs_rd, 32'h12345678);

        // locked read, then reset in the response cycle
        drive(2'b01, 2'b00, 2'b01, 10'h005, 10'd0, 32'd0, 32'd0);
        cycle();
        check_eq("rstmid_gnt", obs_gnt, 2'b01);
        rst = 1'b1;
        drive(2'b00, 2'b00, 2'b00, 10'd0, 10'd0, 32'd0, 32'd0);
        cycle();
        check_eq("rstmid_rv1", obs_rv, 2'b00);
        rst = 1'b0;
        drive(2'b10, 2'b00, 2'b00, 10'd0, 10'h007, 32'd0, 32'd0);
        cycle();
        check_eq("rstmid_rv2", obs_rv, 2'b00);
        check_eq("rstmid_free", obs_gnt, 2'b10);

        // randomized traffic; requesters hold their request until granted
        for (int k = 0; k < 2; k++) pend[k] = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (last_g == k) pend[k] = 1'b0;
                else if (pend[k] && $urandom_range(0, 19) == 0) pend[k] = 1'b0;
                if (!pend[k] && $urandom_range(0, 9) < 6) begin
                    pend[k] = 1'b1;
                    p_we[k] = 1'($urandom_range(0, 1));
                    p_lk[k] = 1'($urandom_range(0, 1));
                    p_ad[k] = ($urandom_range(0, 7) == 0) ? 10'h3FF : 10'($urandom_range(0, 15));
                    p_dt[k] = $urandom;
                end
            end
            rst = ($urandom_range(0, 99) == 0);
            drive({pend[1], pend[0]}, {p_we[1], p_we[0]}, {p_lk[1], p_lk[0]},
                  p_ad[0], p_ad[1], p_dt[0], p_dt[1]);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
